// File: rtl/prog_down_counter_pkg.sv
// Shared definitions for the programmable down-counter: FSM state encoding
// and the width of one counting stage.
package prog_down_counter_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

endpackage

// File: rtl/prog_down_counter_nibble.sv
// One 4-bit down-counting stage (ttl_down_nibble). It decrements when enabled
// and every lower stage is zero, and passes the borrow up the cascade.
module ttl_down_nibble
  import prog_down_counter_pkg::*;
(
  input  logic                clk,
  input  logic                clear_n,
  input  logic                load_n,
  input  logic [NIBBLE_W-1:0] d,
  input  logic                en,
  input  logic                bi,
  output logic [NIBBLE_W-1:0] q,
  output logic                bo
);

  // NOTE: registers use non-blocking assignments so every stage samples the
  // pre-edge value of its neighbours, the same way the chained TTL parts do.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      q <= '0;
    end else if (!load_n) begin
      q <= d;
    end else if (en && bi) begin
      q <= q - NIBBLE_W'(1);
    end
  end

  assign bo = bi && (q == '0);

endmodule

// File: rtl/prog_down_counter.sv
// Cascadable programmable down-counter/divider: FSM, reload register and
// terminal-count pulse around a chain of 4-bit down-counting stages.
module prog_down_counter
  import prog_down_counter_pkg::*;
#(
  parameter int NIBBLES     = 4,
  parameter bit AUTO_RELOAD = 1'b1
) (
  input  logic                        clk,
  input  logic                        clear_n,
  input  logic                        load_n,
  input  logic [NIBBLE_W*NIBBLES-1:0] d,
  input  logic                        start,
  input  logic                        t,
  input  logic                        p,
  output logic [NIBBLE_W*NIBBLES-1:0] q,
  output logic                        bo,
  output logic                        tc_pulse,
  output logic                        busy
);

  localparam int W = NIBBLE_W * NIBBLES;

  state_t         state, state_nx;
  logic [W-1:0]   reload;
  logic [W-1:0]   stage_d;
  logic           stage_load_n;
  logic           run, q_zero, restart, terminal, count;
  logic [NIBBLES:0] borrow;

  assign run     = (state == ST_RUN);
  assign q_zero  = (q == '0);
  assign restart = load_n && start;
  // A step happens only when neither a parallel load nor a restart claims the edge.
  assign terminal = load_n && !start && run && t && p && q_zero;
  assign count    = load_n && !start && run && t && p && !q_zero;

  // Stages share one parallel-load path: external preset or the reload value.
  assign stage_load_n = !(!load_n || restart || (terminal && AUTO_RELOAD));
  assign stage_d      = !load_n ? d : reload;

  assign borrow[0] = t;
  assign bo        = borrow[NIBBLES];

  for (genvar i = 0; i < NIBBLES; i++) begin : g_stage
    ttl_down_nibble u_nibble (
      .clk     (clk),
      .clear_n (clear_n),
      .load_n  (stage_load_n),
      .d       (stage_d[i*NIBBLE_W +: NIBBLE_W]),
      .en      (count),
      .bi      (borrow[i]),
      .q       (q[i*NIBBLE_W +: NIBBLE_W]),
      .bo      (borrow[i+1])
    );
  end

  // NOTE: the next-state default is assigned first so no path leaves
  // state_nx unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    if (restart) begin
      state_nx = ST_RUN;
    end else if (terminal && !AUTO_RELOAD) begin
      state_nx = ST_HALT;
    end
  end

  // NOTE: the reload register sits under the same synchronous clear as the
  // rest of the state, so a clear deliberately discards the reload value.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state    <= ST_IDLE;
      reload   <= '0;
      tc_pulse <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      if (!load_n) begin
        reload <= d;
      end
      tc_pulse <= terminal;
      busy     <= (state_nx == ST_RUN);
    end
  end

endmodule
